// File: rtl/sim_run_monitor_pkg.sv
// Shared constants for the simulation run monitor: state codes, default
// harness addresses and flag level names.
package sim_run_monitor_pkg;

  localparam int MON_STATE_W = 2;

  localparam logic [MON_STATE_W-1:0] MON_RUN      = 2'd0;
  localparam logic [MON_STATE_W-1:0] MON_FINISHED = 2'd1;
  localparam logic [MON_STATE_W-1:0] MON_TIMEDOUT = 2'd2;

  localparam logic [31:0] DEF_FINISH_ADDR = 32'h0000_7fff;
  localparam logic [31:0] DEF_PUTC_ADDR   = 32'h0000_7ff0;

  // Active-high flag levels and their active-low counterparts.
  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE   = 1'b0;
  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

endpackage

// File: rtl/sim_mon_satcnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones
// instead of wrapping.
module sim_mon_satcnt
  import sim_run_monitor_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == ENABLE_N) begin
      q <= '0;
    end else if (clr == ENABLE) begin
      q <= '0;
    end else if ((inc == ENABLE) && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/sim_run_monitor.sv
// Test-harness run monitor: snoops pc and the dmem write port to detect the
// end-of-run store, count cycles and watchpoint hits, and stream console chars.
module sim_run_monitor
  import sim_run_monitor_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                NWATCH      = 4,
  parameter int                CNT_W       = 32,
  parameter logic [DATA_W-1:0] FINISH_ADDR = DATA_W'(DEF_FINISH_ADDR),
  parameter logic [DATA_W-1:0] PUTC_ADDR   = DATA_W'(DEF_PUTC_ADDR),
  parameter int unsigned       MAX_CYCLES  = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        daddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     we,
  input  logic [NWATCH*DATA_W-1:0] watch_pc,
  input  logic [NWATCH-1:0]        watch_en,
  output logic                     running,
  output logic                     finish,
  output logic                     timeout,
  output logic [DATA_W-1:0]        exit_code,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [NWATCH*CNT_W-1:0]  hit_cnt,
  output logic                     putc_vld,
  output logic [7:0]               putc_data
);

  localparam logic        WD_ON   = (MAX_CYCLES != 0);
  localparam logic [63:0] WD_LAST = WD_ON ? (64'(MAX_CYCLES) - 64'd1) : 64'd0;

  logic [MON_STATE_W-1:0] state;
  logic                   in_run;
  logic                   fin_hit;
  logic                   putc_hit;
  logic                   wd_hit;

  assign in_run   = (state == MON_RUN);
  assign running  = in_run;
  assign fin_hit  = in_run && we && (daddr == FINISH_ADDR);
  assign putc_hit = in_run && we && (daddr == PUTC_ADDR);
  // A finish store in the watchdog's last cycle takes precedence.
  assign wd_hit   = in_run && WD_ON && (64'(cycle_cnt) == WD_LAST) && !fin_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == ENABLE_N) begin
      state     <= MON_RUN;
      finish    <= DISABLE;
      timeout   <= DISABLE;
      exit_code <= '0;
      putc_vld  <= DISABLE;
      putc_data <= '0;
    end else if (clr == ENABLE) begin
      state     <= MON_RUN;
      finish    <= DISABLE;
      timeout   <= DISABLE;
      exit_code <= '0;
      putc_vld  <= DISABLE;
      putc_data <= '0;
    end else begin
      putc_vld <= putc_hit ? ENABLE : DISABLE;
      if (putc_hit) begin
        putc_data <= wdata[7:0];
      end
      if (fin_hit) begin
        state     <= MON_FINISHED;
        finish    <= ENABLE;
        exit_code <= wdata;
      end else if (wd_hit) begin
        state   <= MON_TIMEDOUT;
        timeout <= ENABLE;
      end
    end
  end

  sim_mon_satcnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (in_run),
    .q     (cycle_cnt)
  );

  // One independent counter per watchpoint channel; several may hit together.
  for (genvar k = 0; k < NWATCH; k++) begin : g_watch
    logic hit;
    assign hit = in_run && watch_en[k] && (pc == watch_pc[k*DATA_W +: DATA_W]);

    sim_mon_satcnt #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (hit),
      .q     (hit_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_sim_run_monitor.sv
// Randomised directed bench for sim_run_monitor: three instances (default,
// short watchdog, narrow counters) share inputs and are compared to a model.
module tb_sim_run_monitor;

  localparam logic [31:0] FIN_A  = 32'h0000_7fff;
  localparam logic [31:0] PUTC_A = 32'h0000_7ff0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic [31:0]  pc;
  logic [31:0]  daddr;
  logic [31:0]  wdata;
  logic         we;
  logic [127:0] watch_pc;
  logic [3:0]   watch_en;

  logic         run_a, fin_a, to_a, pv_a;
  logic [31:0]  exit_a, cyc_a;
  logic [127:0] hit_a;
  logic [7:0]   pd_a;

  logic         run_b, fin_b, to_b, pv_b;
  logic [31:0]  exit_b, cyc_b;
  logic [127:0] hit_b;
  logic [7:0]   pd_b;

  logic         run_c, fin_c, to_c, pv_c;
  logic [31:0]  exit_c;
  logic [3:0]   cyc_c;
  logic [15:0]  hit_c;
  logic [7:0]   pd_c;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, one slot per instance.
  logic        m_fin [3];
  logic        m_to  [3];
  logic [31:0] m_exit[3];
  longint      m_cyc [3];
  longint      m_hit [3][4];
  logic        m_pv  [3];
  logic [7:0]  m_pd  [3];

  longint max_cyc[3] = '{100000, 20, 0};
  longint cnt_max[3] = '{64'hffff_ffff, 64'hffff_ffff, 64'd15};

  always #5 clk = ~clk;

  sim_run_monitor dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .pc(pc), .daddr(daddr), .wdata(wdata),
    .we(we), .watch_pc(watch_pc), .watch_en(watch_en), .running(run_a),
    .finish(fin_a), .timeout(to_a), .exit_code(exit_a), .cycle_cnt(cyc_a),
    .hit_cnt(hit_a), .putc_vld(pv_a), .putc_data(pd_a)
  );

  sim_run_monitor #(.MAX_CYCLES(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .pc(pc), .daddr(daddr), .wdata(wdata),
    .we(we), .watch_pc(watch_pc), .watch_en(watch_en), .running(run_b),
    .finish(fin_b), .timeout(to_b), .exit_code(exit_b), .cycle_cnt(cyc_b),
    .hit_cnt(hit_b), .putc_vld(pv_b), .putc_data(pd_b)
  );

  sim_run_monitor #(.CNT_W(4), .MAX_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .pc(pc), .daddr(daddr), .wdata(wdata),
    .we(we), .watch_pc(watch_pc), .watch_en(watch_en), .running(run_c),
    .finish(fin_c), .timeout(to_c), .exit_code(exit_c), .cycle_cnt(cyc_c),
    .hit_cnt(hit_c), .putc_vld(pv_c), .putc_data(pd_c)
  );

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset(input int i);
    m_fin[i]  = 1'b0;
    m_to[i]   = 1'b0;
    m_exit[i] = '0;
    m_cyc[i]  = 0;
    for (int k = 0; k < 4; k++) m_hit[i][k] = 0;
    m_pv[i]   = 1'b0;
    m_pd[i]   = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep(input int i);
    logic fin_st, putc_st;
    if (clr) begin
      modelReset(i);
      return;
    end
    if (m_fin[i] || m_to[i]) begin
      m_pv[i] = 1'b0;
      return;
    end
    fin_st  = we && (daddr == FIN_A);
    putc_st = we && (daddr == PUTC_A);
    if (fin_st) begin
      m_fin[i]  = 1'b1;
      m_exit[i] = wdata;
    end else if (max_cyc[i] != 0 && m_cyc[i] + 1 == max_cyc[i]) begin
      m_to[i] = 1'b1;
    end
    if (m_cyc[i] < cnt_max[i]) m_cyc[i]++;
    for (int k = 0; k < 4; k++)
      if (watch_en[k] && pc == watch_pc[k*32 +: 32] && m_hit[i][k] < cnt_max[i])
        m_hit[i][k]++;
    m_pv[i] = putc_st;
    if (putc_st) m_pd[i] = wdata[7:0];
  endtask

  task automatic checkInst(input int i, input logic r, input logic f, input logic t,
                           input logic [31:0] ex, input logic [63:0] cyc,
                           input logic [255:0] hits, input logic v, input logic [7:0] d);
    string n;
    n = $sformatf("inst%0d", i);
    cmp({n, "_running"}, 64'(r), 64'(!(m_fin[i] || m_to[i])));
    cmp({n, "_finish"}, 64'(f), 64'(m_fin[i]));
    cmp({n, "_timeout"}, 64'(t), 64'(m_to[i]));
    cmp({n, "_exit_code"}, 64'(ex), 64'(m_exit[i]));
    cmp({n, "_cycle_cnt"}, cyc, 64'(m_cyc[i]));
    for (int k = 0; k < 4; k++)
      cmp($sformatf("%s_hit_cnt%0d", n, k), hits[k*64 +: 64], 64'(m_hit[i][k]));
    cmp({n, "_putc_vld"}, 64'(v), 64'(m_pv[i]));
    cmp({n, "_putc_data"}, 64'(d), 64'(m_pd[i]));
  endtask

  function automatic logic [255:0] widen32(input logic [127:0] h);
    logic [255:0] r;
    for (int k = 0; k < 4; k++) r[k*64 +: 64] = 64'(h[k*32 +: 32]);
    return r;
  endfunction

  function automatic logic [255:0] widen4(input logic [15:0] h);
    logic [255:0] r;
    for (int k = 0; k < 4; k++) r[k*64 +: 64] = 64'(h[k*4 +: 4]);
    return r;
  endfunction

  task automatic checkOutput();
    checkInst(0, run_a, fin_a, to_a, exit_a, 64'(cyc_a), widen32(hit_a), pv_a, pd_a);
    checkInst(1, run_b, fin_b, to_b, exit_b, 64'(cyc_b), widen32(hit_b), pv_b, pd_b);
    checkInst(2, run_c, fin_c, to_c, exit_c, 64'(cyc_c), widen4(hit_c), pv_c, pd_c);
  endtask

  task automatic applyStimulus(input logic c, input logic [31:0] p, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    clr = c; pc = p; we = w; daddr = a; wdata = d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) modelStep(i);
    #1;
    checkOutput();
  endtask

  function automatic logic [31:0] pickPc();
    case ($urandom_range(0, 3))
      0:       return 32'h30;
      1:       return 32'h34;
      2:       return watch_pc[127:96];
      default: return $urandom;
    endcase
  endfunction

  // Random non-finishing store target: console, or some other address.
  function automatic logic [31:0] pickAddr();
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0) return PUTC_A;
    a = 32'h1000 + 32'($urandom_range(0, 255));
    return a;
  endfunction

  task automatic asyncReset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) modelReset(i);
    #1;
    checkOutput();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; pc = '0; daddr = '0; wdata = '0; we = 1'b0;
    watch_pc = {32'h40, 32'h34, 32'h30, 32'h30};
    watch_en = 4'b1101;
    for (int i = 0; i < 3; i++) modelReset(i);
    #12;
    checkOutput();
    cmp("reset_running", 64'(run_a), 64'd1);
    rst_n = 1'b1;

    $display("[TB] finish store in cycle 50");
    for (int c = 0; c < 50; c++)
      applyStimulus(1'b0, pickPc(), 1'($urandom_range(0, 1)), pickAddr(), $urandom);
    applyStimulus(1'b0, pickPc(), 1'b1, FIN_A, 32'h2a);
    cmp("t1_finish", 64'(fin_a), 64'd1);
    cmp("t1_exit_code", 64'(exit_a), 64'h2a);
    cmp("t1_cycle_cnt", 64'(cyc_a), 64'd51);
    cmp("t1_running", 64'(run_a), 64'd0);
    cmp("t2_timeout", 64'(to_b), 64'd1);
    cmp("t2_finish_ignored", 64'(fin_b), 64'd0);
    cmp("t2_cycle_cnt", 64'(cyc_b), 64'd20);
    applyStimulus(1'b0, pickPc(), 1'b1, FIN_A, 32'h77);
    cmp("t1_exit_frozen", 64'(exit_a), 64'h2a);

    $display("[TB] finish store in the watchdog's last cycle");
    applyStimulus(1'b1, pickPc(), 1'b1, FIN_A, 32'h99);
    cmp("clr_running", 64'(run_b), 64'd1);
    for (int c = 0; c < 19; c++)
      applyStimulus(1'b0, pickPc(), 1'($urandom_range(0, 1)), pickAddr(), $urandom);
    applyStimulus(1'b0, pickPc(), 1'b1, FIN_A, 32'h55);
    cmp("t3_finish", 64'(fin_b), 64'd1);
    cmp("t3_timeout", 64'(to_b), 64'd0);
    cmp("t3_cycle_cnt", 64'(cyc_b), 64'd20);

    $display("[TB] watchpoint enable");
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 10; c++)
      applyStimulus(1'b0, (c < 7) ? 32'h30 : 32'h44, 1'b0, pickAddr(), $urandom);
    cmp("t4_hit0", 64'(hit_a[31:0]), 64'd7);
    cmp("t4_hit1", 64'(hit_a[63:32]), 64'd0);

    $display("[TB] console stream");
    applyStimulus(1'b0, 32'h0, 1'b1, PUTC_A, 32'hdead_be48);
    cmp("t5_vld_h", 64'(pv_a), 64'd1);
    cmp("t5_data_h", 64'(pd_a), 64'h48);
    applyStimulus(1'b0, 32'h0, 1'b1, PUTC_A, 32'h0000_0069);
    cmp("t5_vld_i", 64'(pv_a), 64'd1);
    cmp("t5_data_i", 64'(pd_a), 64'h69);
    applyStimulus(1'b0, 32'h0, 1'b0, PUTC_A, 32'h0);
    cmp("t5_vld_off", 64'(pv_a), 64'd0);
    cmp("t5_running", 64'(run_a), 64'd1);

    $display("[TB] saturation, clear and asynchronous reset");
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 20; c++)
      applyStimulus(1'b0, 32'h30, 1'b0, pickAddr(), $urandom);
    cmp("t6_hit_sat", 64'(hit_c[3:0]), 64'd15);
    cmp("t6_cyc_sat", 64'(cyc_c), 64'd15);
    applyStimulus(1'b1, 32'h30, 1'b1, FIN_A, 32'h1);
    cmp("t6_clr_hit", 64'(hit_c), 64'd0);
    cmp("t6_clr_run_b", 64'(run_b), 64'd1);
    for (int c = 0; c < 5; c++)
      applyStimulus(1'b0, pickPc(), 1'b1, pickAddr(), $urandom);
    asyncReset();
    cmp("t6_rst_cyc", 64'(cyc_a), 64'd0);

    $display("[TB] random run");
    watch_pc = {$urandom, 32'h34, 32'h30, 32'h30};
    for (int c = 0; c < 400; c++) begin
      logic        cl, w;
      logic [31:0] a;
      cl = ($urandom_range(0, 49) == 0);
      w  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 29) == 0) ? FIN_A : pickAddr();
      if (c % 97 == 50) watch_en = 4'($urandom);
      applyStimulus(cl, pickPc(), w, a, $urandom);
      if ($urandom_range(0, 149) == 0) asyncReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
